// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-port no-handshake FIFO: width helpers and modulo add.
package fifo_pkg;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // b may exceed n (head may advance by pops plus discarded entries), so a full modulo is used
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/fifo_nohs_mp_ptr.sv
// Modulo-DEPTH pointer register with per-lane offset pointers; used for both head and tail.
module fifo_nohs_mp_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int N_LANE = 2,
  parameter int AW     = 3,
  parameter int IW     = 3
)(
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clear_i,
  input  logic [IW-1:0] inc_i,
  output logic [AW-1:0] ptr_o,
  output logic [AW-1:0] lane_ptr_o [N_LANE]
);

  logic [AW-1:0] ptr_r;

  // Pointer state: clear wins over increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_r <= '0;
    end else if (clear_i) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= AW'(mod_add(32'(ptr_r), 32'(inc_i), 32'(DEPTH)));
    end
  end

  // Per-lane offsets from the base pointer
  always_comb begin
    ptr_o = ptr_r;
    for (int k = 0; k < N_LANE; k++) begin
      lane_ptr_o[k] = AW'(mod_add(32'(ptr_r), 32'(k), 32'(DEPTH)));
    end
  end

endmodule

// File: rtl/fifo_nohs_mp.sv
// Multi-port FIFO without valid/ready handshake: up to N_PUSH writes and N_POP reads per cycle.
// Optional FIFO_NOHS_MP_OVERWRITE_EN: on overflow overwrite the oldest entries instead of dropping.
module fifo_nohs_mp
  import fifo_pkg::*;
#(
  parameter type DATA_T = logic [7:0],
  parameter int  DEPTH  = 8,
  parameter int  N_PUSH = 2,
  parameter int  N_POP  = 2,
  localparam int CW     = $clog2(DEPTH+1),
  localparam int PW     = $clog2(N_PUSH+1),
  localparam int QW     = $clog2(N_POP+1)
)(
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic [PW-1:0] push_cnt_i,
  input  DATA_T         data_i [N_PUSH],
  input  logic [QW-1:0] pop_cnt_i,
  output DATA_T         data_o [N_POP],
  output logic [N_POP-1:0] valid_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int AW      = ptr_width(DEPTH);
  localparam int INC_MAX = max2(N_PUSH, N_POP) + N_PUSH;
  localparam int IW      = $clog2(INC_MAX+1);

  DATA_T             mem_r [DEPTH];
  logic [CW-1:0]     count_r;
  logic              overflow_r;
  logic              underflow_r;

  logic [AW-1:0]     head_s;
  logic [AW-1:0]     tail_s;
  logic [AW-1:0]     head_lane_s [N_POP];
  logic [AW-1:0]     tail_lane_s [N_PUSH];
  logic [IW-1:0]     head_inc_s;
  logic [IW-1:0]     tail_inc_s;
  logic [CW-1:0]     count_nxt_s;
  logic [N_PUSH-1:0] wr_en_s;
  logic              overflow_nxt_s;
  logic              underflow_nxt_s;

  int count_s;
  int push_s;
  int pop_s;
  int pop_eff_s;
  int free_s;
  int push_eff_s;
  int excess_s;

  fifo_nohs_mp_ptr #(
    .DEPTH  (DEPTH),
    .N_LANE (N_POP),
    .AW     (AW),
    .IW     (IW)
  ) u_head (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (flush_i),
    .inc_i      (head_inc_s),
    .ptr_o      (head_s),
    .lane_ptr_o (head_lane_s)
  );

  fifo_nohs_mp_ptr #(
    .DEPTH  (DEPTH),
    .N_LANE (N_PUSH),
    .AW     (AW),
    .IW     (IW)
  ) u_tail (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (flush_i),
    .inc_i      (tail_inc_s),
    .ptr_o      (tail_s),
    .lane_ptr_o (tail_lane_s)
  );

  // Pop/push arbitration: popped slots are free for pushes in the same cycle
  always_comb begin
    count_s         = int'(count_r);
    push_s          = int'(push_cnt_i);
    pop_s           = int'(pop_cnt_i);
    pop_eff_s       = (pop_s > count_s) ? count_s : pop_s;
    free_s          = DEPTH - count_s + pop_eff_s;
    push_eff_s      = push_s;
    excess_s        = 0;
    wr_en_s         = '0;
    count_nxt_s     = count_r;
    head_inc_s      = '0;
    tail_inc_s      = '0;
    overflow_nxt_s  = 1'b0;
    underflow_nxt_s = 1'b0;

    if (push_s > free_s) begin
`ifdef FIFO_NOHS_MP_OVERWRITE_EN
      excess_s   = push_s - free_s;
`else
      push_eff_s = free_s;
`endif
    end else begin
      push_eff_s = push_s;
    end

    if (flush_i) begin
      count_nxt_s = '0;
    end else begin
      // Tail slots beyond free are the oldest entries when overwriting, so writes stay in-lane
      for (int k = 0; k < N_PUSH; k++) begin
        wr_en_s[k] = (k < push_eff_s);
      end
      count_nxt_s     = CW'(count_s + push_eff_s - pop_eff_s - excess_s);
      head_inc_s      = IW'(pop_eff_s + excess_s);
      tail_inc_s      = IW'(push_eff_s);
      overflow_nxt_s  = (push_s > free_s);
      underflow_nxt_s = (pop_s > count_s);
    end
  end

  // Occupancy and one-cycle error pulses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Storage array; flush leaves contents in place
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int k = 0; k < N_PUSH; k++) begin
        if (wr_en_s[k]) begin
          mem_r[tail_lane_s[k]] <= data_i[k];
        end
      end
    end
  end

  // Read lanes and status derived from registered state only
  always_comb begin
    for (int j = 0; j < N_POP; j++) begin
      data_o[j]  = mem_r[head_lane_s[j]];
      valid_o[j] = (j < int'(count_r));
    end
    count_o     = count_r;
    full_o      = (int'(count_r) == DEPTH);
    empty_o     = (count_r == '0);
    overflow_o  = overflow_r;
    underflow_o = underflow_r;
  end

`ifndef SYNTHESIS
  fifo_nohs_mp_chk #(
    .N_PUSH (N_PUSH),
    .N_POP  (N_POP),
    .PW     (PW),
    .QW     (QW)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_cnt_i (push_cnt_i),
    .pop_cnt_i  (pop_cnt_i)
  );
`endif

endmodule

// Illegal lane-count checks for simulation builds.
module fifo_nohs_mp_chk #(
  parameter int N_PUSH = 2,
  parameter int N_POP  = 2,
  parameter int PW     = 2,
  parameter int QW     = 2
)(
  input logic          clk_i,
  input logic          rst_n_i,
  input logic [PW-1:0] push_cnt_i,
  input logic [QW-1:0] pop_cnt_i
);

  a_push_cnt_legal: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                     int'(push_cnt_i) <= N_PUSH);
  a_pop_cnt_legal:  assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                     int'(pop_cnt_i) <= N_POP);

endmodule

// File: tb/tb_fifo_nohs_mp.sv
// Directed, scoreboard-based bench for fifo_nohs_mp at DEPTH=4, two push and two pop lanes.
module tb_fifo_nohs_mp;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] push_cnt;
  logic [1:0] pop_cnt;
  logic [7:0] data_in  [2];
  logic [7:0] data_out [2];
  logic [1:0] valid;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       unf;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb_q [$];
  logic       exp_ovf;
  logic       exp_unf;

  always #5 clk = ~clk;

  fifo_nohs_mp #(
    .DATA_T (logic [7:0]),
    .DEPTH  (DEPTH),
    .N_PUSH (2),
    .N_POP  (2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .push_cnt_i  (push_cnt),
    .data_i      (data_in),
    .pop_cnt_i   (pop_cnt),
    .data_o      (data_out),
    .valid_o     (valid),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .overflow_o  (ovf),
    .underflow_o (unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int         n;
    logic [1:0] ev;
    n = sb_q.size();
    ev = 2'b00;
    for (int j = 0; j < 2; j++) begin
      ev[j] = (j < n);
    end
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"},  32'(full),  32'(n == DEPTH));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".ovf"},   32'(ovf),   32'(exp_ovf));
    chk({tag, ".unf"},   32'(unf),   32'(exp_unf));
    for (int j = 0; j < 2; j++) begin
      if (j < n) begin
        chk($sformatf("%s.data%0d", tag, j), 32'(data_out[j]), 32'(sb_q[j]));
      end
    end
  endtask

  // Drive one cycle, update the scoreboard with the expected effect, then check after the edge
  task automatic step(input string tag, input int push, input logic [7:0] d0,
                      input logic [7:0] d1, input int pop, input logic fl);
    int         n;
    int         pe;
    int         free;
    logic [7:0] d [2];
    d[0] = d0;
    d[1] = d1;
    data_in[0] = d0;
    data_in[1] = d1;
    push_cnt   = 2'(push);
    pop_cnt    = 2'(pop);
    flush      = fl;
    n = sb_q.size();
    if (fl) begin
      sb_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      pe      = (pop > n) ? n : pop;
      exp_unf = (pop > n);
      free    = DEPTH - n + pe;
      exp_ovf = (push > free);
      repeat (pe) void'(sb_q.pop_front());
      for (int k = 0; k < push; k++) begin
        if (k < free) begin
          sb_q.push_back(d[k]);
        end else begin
`ifdef FIFO_NOHS_MP_OVERWRITE_EN
          void'(sb_q.pop_front());
          sb_q.push_back(d[k]);
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
    push_cnt = 2'd0;
    pop_cnt  = 2'd0;
    flush    = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    push_cnt   = 2'd0;
    pop_cnt    = 2'd0;
    data_in[0] = 8'h00;
    data_in[1] = 8'h00;
    exp_ovf    = 1'b0;
    exp_unf    = 1'b0;
    #12;
    check_all("reset");
    chk("reset.data0", 32'(data_out[0]), 32'h0);
    chk("reset.data1", 32'(data_out[1]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("push2",     2, 8'hA1, 8'hA2, 0, 1'b0);
    step("push1",     1, 8'hA3, 8'h00, 0, 1'b0);
    step("overflow",  2, 8'hB1, 8'hB2, 0, 1'b0);
    step("full_swap", 2, 8'hC1, 8'hC2, 2, 1'b0);
    step("full_idle", 0, 8'h00, 8'h00, 0, 1'b0);
    step("pop2",      0, 8'h00, 8'h00, 2, 1'b0);
    step("pop1",      0, 8'h00, 8'h00, 1, 1'b0);
    step("underflow", 0, 8'h00, 8'h00, 2, 1'b0);
    step("unf_clear", 0, 8'h00, 8'h00, 0, 1'b0);

    step("prime",     1, 8'h40, 8'h00, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step($sformatf("wrap%0d", i), 1, 8'(8'h41 + i), 8'h00, 1, 1'b0);
    end

    step("pre_flush", 2, 8'hD1, 8'hD2, 0, 1'b0);
    step("flush",     2, 8'hE1, 8'hE2, 0, 1'b1);
    step("post_push", 2, 8'hF1, 8'hF2, 0, 1'b0);

    #3;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_all("async_rst");
    chk("async_rst.data0", 32'(data_out[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("after_rst", 1, 8'h5A, 8'h00, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
